// File: rtl/display_mux_if.sv
// display_mux_if: load handshake and display-drive signals of display_mux_ctrl.
interface display_mux_if #(parameter int NUM_DIGITS = 2);
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic enable;
  logic load_valid;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic load_ready;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [3:0] nibble_out;
  logic [SW-1:0] slot_idx;
  logic frame_tick;
  modport master (output enable, load_valid, load_data,
                  input load_ready, digit_en, nibble_out, slot_idx, frame_tick);
  modport slave (input enable, load_valid, load_data,
                 output load_ready, digit_en, nibble_out, slot_idx, frame_tick);
endinterface

// File: rtl/display_mux_ctrl.sv
// display_mux_ctrl: multiplexed 7-segment digit sequencer with blanking and frame-coherent digit updates.
module display_mux_ctrl #(
  parameter int NUM_DIGITS    = 2,
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_CYCLES  = 1000,
  parameter bit EN_ACTIVE_LOW = 1'b0
) (
  input logic clk,
  input logic reset,
  display_mux_if.slave bus
);
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int TMAX = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] EN_OFF = EN_ACTIVE_LOW ? '1 : '0;
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] slot_q, slot_d, slot_nx;
  logic [DW-1:0] disp_q, disp_d, pend_q, pend_d;
  logic pv_q, pv_d, tick_q, tick_d, frame_start;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [3:0] nib_q, nib_d;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    slot_d = slot_q;
    disp_d = disp_q;
    pend_d = pend_q;
    pv_d = pv_q;
    slot_nx = slot_q == SW'(NUM_DIGITS - 1) ? '0 : slot_q + 1'b1;
    if (!bus.enable) begin
      state_d = IDLE;
      timer_d = '0;
      slot_d = '0;
    end else if (state_q == IDLE) begin
      state_d = SHOW;
      timer_d = '0;
      slot_d = '0;
    end else if (state_q == SHOW && timer_q == TW'(REFRESH_DIV - 1)) begin
      state_d = BLANK_CYCLES == 0 ? SHOW : BLANK;
      timer_d = '0;
      slot_d = BLANK_CYCLES == 0 ? slot_nx : slot_q;
    end else if (state_q == BLANK && timer_q == TW'(BLANK_CYCLES - 1)) begin
      state_d = SHOW;
      timer_d = '0;
      slot_d = slot_nx;
    end
    // A SHOW cycle with timer 0 is always the first cycle of a slot
    frame_start = state_d == SHOW && slot_d == '0 && timer_d == '0;
    if (frame_start && pv_q) begin
      disp_d = pend_q;
      pv_d = 1'b0;
    end
    if (bus.load_valid && !pv_q) begin
      pend_d = bus.load_data;
      pv_d = 1'b1;
    end
    tick_d = frame_start;
    en_d = (state_d == SHOW ? NUM_DIGITS'(1) << slot_d : '0) ^ EN_OFF;
    nib_d = state_d == SHOW ? 4'(disp_d >> {slot_d, 2'b00}) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      slot_q <= '0;
      disp_q <= '0;
      pend_q <= '0;
      pv_q <= 1'b0;
      tick_q <= 1'b0;
      en_q <= EN_OFF;
      nib_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      slot_q <= slot_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      pv_q <= pv_d;
      tick_q <= tick_d;
      en_q <= en_d;
      nib_q <= nib_d;
    end
  end
  assign bus.load_ready = ~pv_q;
  assign bus.digit_en = en_q;
  assign bus.nibble_out = nib_q;
  assign bus.slot_idx = slot_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_display_mux_ctrl.sv
// tb_display_mux_ctrl: two configurations driven in lockstep and checked against a frame-position model.
module tb_display_mux_ctrl;
  localparam int N = 2, RD = 4;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, load_valid = 1'b0;
  logic [7:0] load_data = '0;
  int n_chk = 0, n_pass = 0;
  int bc[2] = '{2, 0};
  bit al[2] = '{1'b0, 1'b1};
  bit run[2], pv[2], fs[2];
  int pos[2];
  logic [7:0] disp[2], pend[2];
  always #5 clk = ~clk;
  display_mux_if #(.NUM_DIGITS(N)) b0 ();
  display_mux_if #(.NUM_DIGITS(N)) b1 ();
  assign b0.enable = enable;
  assign b0.load_valid = load_valid;
  assign b0.load_data = load_data;
  assign b1.enable = enable;
  assign b1.load_valid = load_valid;
  assign b1.load_data = load_data;
  display_mux_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(2), .EN_ACTIVE_LOW(1'b0))
    dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  display_mux_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(0), .EN_ACTIVE_LOW(1'b1))
    dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // pos counts cycles since the last frame start; slot and show/blank follow by division
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit acc;
      acc = load_valid && !pv[i];
      fs[i] = 1'b0;
      if (reset) begin
        run[i] = 1'b0; pos[i] = 0; disp[i] = '0; pend[i] = '0; pv[i] = 1'b0;
        continue;
      end
      if (!enable) begin
        run[i] = 1'b0; pos[i] = 0;
      end else if (!run[i]) begin
        run[i] = 1'b1; pos[i] = 0; fs[i] = 1'b1;
      end else begin
        pos[i] = (pos[i] + 1) % (N * (RD + bc[i]));
        fs[i] = pos[i] == 0;
      end
      if (fs[i] && pv[i]) begin disp[i] = pend[i]; pv[i] = 1'b0; end
      if (acc) begin pend[i] = load_data; pv[i] = 1'b1; end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int p, sl;
      bit show;
      logic [1:0] en;
      logic [3:0] nib;
      string t;
      t = i == 0 ? "d0" : "d1";
      p = RD + bc[i];
      sl = run[i] ? pos[i] / p : 0;
      show = run[i] && (pos[i] % p) < RD;
      en = (show ? 2'(1 << sl) : 2'b00) ^ (al[i] ? 2'b11 : 2'b00);
      nib = show ? 4'(disp[i] >> (4 * sl)) : 4'h0;
      check({t, " digit_en"}, i == 0 ? b0.digit_en : b1.digit_en, en);
      check({t, " nibble_out"}, i == 0 ? b0.nibble_out : b1.nibble_out, nib);
      check({t, " slot_idx"}, i == 0 ? b0.slot_idx : b1.slot_idx, sl);
      check({t, " frame_tick"}, i == 0 ? b0.frame_tick : b1.frame_tick, fs[i]);
      check({t, " load_ready"}, i == 0 ? b0.load_ready : b1.load_ready, !pv[i]);
    end
  endtask

  task automatic cycle(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      @(negedge clk);
    end
  endtask

  task automatic run_until_slot1_show();
    for (int k = 0; k < 40 && !(run[0] && pos[0] >= RD + 2 && pos[0] < 2 * RD + 2); k++) cycle();
  endtask

  initial begin
    @(negedge clk);
    cycle(2);
    check("reset digit_en inverted", b1.digit_en, 2'b11);
    reset = 1'b0;
    enable = 1'b1;
    cycle(30);
    run_until_slot1_show();
    load_valid = 1'b1;
    load_data = 8'h5A;
    cycle();
    load_data = 8'h33;
    cycle(30);
    load_valid = 1'b0;
    cycle(15);
    run_until_slot1_show();
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    cycle(15);
    load_valid = 1'b1;
    load_data = 8'hC7;
    cycle();
    load_valid = 1'b0;
    for (int k = 0; k < 20 && !(run[0] && pos[0] % (RD + 2) >= RD); k++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle(15);
    for (int k = 0; k < 1500; k++) begin
      reset = $urandom_range(199) == 0;
      enable = $urandom_range(49) != 0;
      load_valid = $urandom_range(3) == 0;
      load_data = 8'($urandom);
      cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/display_mux_ctrl.md
Name: display_mux_ctrl

Overview:
Time-multiplexing controller for the shared common-segment 7-segment display. It owns digit-select sequencing, the refresh timer and inter-digit blanking (anti-ghosting). It also performs atomic, frame-coherent updates of the per-digit 4-bit values. Its outputs feed the existing segment decoder (nibble_out) and the digit-select pins (digit_en); the decoder itself is not part of this block.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (>=2)
REFRESH_DIV, 100000, clk cycles each digit is lit per slot (>=1)
BLANK_CYCLES, 1000, clk cycles all digits are off between slots (0 = no blanking)
EN_ACTIVE_LOW, 0, 1 inverts every digit_en bit at the output (polarity only, no logic change)

Ports:
clk  in  1  system clock (HSOSC-derived)
reset  in  1  synchronous, active-high reset
enable  in  1  run multiplexing; 0 forces all digits off
load_valid  in  1  new digit values offered
load_data  in  4*NUM_DIGITS  digit values, digit k at [4k+3:4k]
load_ready  out  1  controller can accept load_data
digit_en  out  NUM_DIGITS  one-hot digit select (polarity per EN_ACTIVE_LOW)
nibble_out  out  4  value of currently lit digit, to segment decoder
slot_idx  out  max(1,$clog2(NUM_DIGITS))  index of current/last slot
frame_tick  out  1  one-cycle pulse at start of each frame

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset. All state updates on posedge clk.
- All outputs registered. Reset values:
  - FSM=IDLE, timer=0, slot_idx=0
  - display_reg=0, pending_reg=0, pending_valid=0
  - digit_en=all-off (0, or all-1 if EN_ACTIVE_LOW)
  - nibble_out=0, frame_tick=0, load_ready=1
- Reset mid-operation: same values on the next edge. Any pending update is discarded.
- FSM states: IDLE, SHOW, BLANK.
  - IDLE: digits off. enable=1 -> SHOW with slot 0, timer=0 (a frame start).
  - SHOW: digit_en one-hot at slot_idx; nibble_out=display_reg[4*slot_idx+:4]. Lasts exactly REFRESH_DIV cycles (timer 0..REFRESH_DIV-1). At terminal count -> BLANK, timer=0; if BLANK_CYCLES=0 go directly to SHOW of the next slot.
  - BLANK: digit_en all-off, nibble_out=0, slot_idx held. Lasts exactly BLANK_CYCLES cycles, then SHOW of (slot_idx+1) mod NUM_DIGITS, timer=0.
  - enable=0 in any state: IDLE on the next edge, timer=0, slot_idx=0. display_reg and pending state are retained.
- Frame start: any entry into SHOW with slot 0, whether from IDLE, BLANK wrap, or SHOW wrap when BLANK_CYCLES=0.
  - frame_tick=1 in the first SHOW cycle of slot 0 only.
  - If pending_valid=1 at the edge entering that cycle: display_reg<=pending_reg and pending_valid<=0 on that edge. The first cycle already shows the new value.
- Load handshake:
  - load_ready = ~pending_valid (registered).
  - Transfer occurs when load_valid && load_ready at an edge: pending_reg<=load_data, pending_valid<=1.
  - Only one pending update is held; the producer stalls until commit.
  - load_data is sampled only on transfer. load_valid is ignored while load_ready=0.
  - A load may be accepted in IDLE. It commits at the next frame start.
- Timing: slot period = REFRESH_DIV+BLANK_CYCLES cycles. Frame period = NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES).
- Invariants: never more than one digit lit; digit_en all-off in IDLE and BLANK.
- Arithmetic: timer sized $clog2(max(REFRESH_DIV,BLANK_CYCLES)+1). slot_idx wraps NUM_DIGITS-1 -> 0.

Test Plan:
(Parameters for all: NUM_DIGITS=2, REFRESH_DIV=4, BLANK_CYCLES=2, EN_ACTIVE_LOW=0.)
1. Reset then enable=1 at cycle 0 -> digit_en sequence from cycle 1: 01 x4, 00 x2, 10 x4, 00 x2, repeating (12-cycle frame). frame_tick=1 at cycles 1, 13, 25.
2. load_data=8'h5A, load_valid=1 for one cycle while in slot 1 -> load_ready=0 next cycle. At the next frame start nibble_out=A with digit_en=01, then 5 in slot 1. load_ready returns to 1 after the commit edge.
3. Second load 8'h33 offered while pending 8'h5A is uncommitted -> not accepted (load_ready=0). After commit it is accepted. Display shows 5A for one full frame, then 33.
4. enable dropped mid-SHOW of slot 1 -> next cycle digit_en=00, slot_idx=0. Re-enable -> restarts at slot 0 with frame_tick, display_reg unchanged.
5. Assert reset during BLANK with a pending load -> all outputs at reset values next cycle, pending discarded, and nibble_out=0 after re-enable.
6. BLANK_CYCLES=0 -> digit_en alternates 01 x4, 10 x4 with no gap. EN_ACTIVE_LOW=1 -> same waveform inverted, IDLE shows 11.
